tt_ksa_frame_subtractor: RTL and testbench

Byte-serial multi-byte subtractor for the Tiny Tapeout tile, the inverse companion of the combinational tile adder. It recovers one operand from a sum: it accepts an NBYTES-wide minuend and subtrahend as LSB-first byte pairs through the dedicated inputs. Each pair produces one difference byte, with the borrow carried in a register between bytes. Control strobes arrive on the bidirectional pins and status is driven back on the upper bidirectional pins, so a host with only the tile pins can run arbitrarily wide subtractions.

---
 rtl/tt_ksa_frame_subtractor_if.sv | 13 +
 rtl/tt_ksa_frame_subtractor.sv | 126 ++++++++++++
 tb/tb_tt_ksa_frame_subtractor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tt_ksa_frame_subtractor_if.sv
// Tile pin bundle for the byte-serial frame subtractor: host-driven inputs and
// tile-driven outputs, split into host (master) and tile (slave) views.
interface tt_ksa_frame_subtractor_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_ksa_frame_subtractor.sv
// Byte-serial NBYTES-wide subtractor: LSB-first A/B byte pairs arrive on strobe
// events, one difference byte per pair with the borrow carried between bytes.
module tt_ksa_frame_subtractor #(
    parameter int NBYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tt_ksa_frame_subtractor_if.slave    bus
);
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, DONE} state_e;

    state_e          state_q, state_d, eff_st;
    logic            s1_q, s2_q, s3_q;
    logic [7:0]      a_hold_q, a_hold_d;
    logic            borrow_q, borrow_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      uo_q, uo_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            bout_q, bout_d, err_q, err_d;
    logic            evt, start, sel;
    logic [8:0]      diff;
    logic            unused_ok;

    assign evt   = s2_q & ~s3_q;
    assign start = bus.uio_in[1];
    assign sel   = bus.uio_in[2];
    assign diff  = {1'b0, a_hold_q} - {1'b0, bus.ui_in} - {8'd0, borrow_q};

    assign unused_ok = ^{bus.ena, bus.uio_in[7:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.uio_in[0];
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_hold_q <= 8'h00;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            uo_q     <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_hold_q <= a_hold_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            uo_q     <= uo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bout_q   <= bout_d;
            err_q    <= err_d;
        end
    end

    // A start first resets the frame, then its byte is handled as a WAIT_A byte.
    always_comb begin
        state_d  = state_q;
        a_hold_d = a_hold_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        uo_d     = uo_q;
        busy_d   = busy_q;
        done_d   = done_q;
        bout_d   = bout_q;
        err_d    = err_q;
        eff_st   = state_q;
        if (evt) begin
            if (start) begin
                borrow_d = 1'b0;
                cnt_d    = '0;
                err_d    = 1'b0;
                done_d   = 1'b0;
                bout_d   = 1'b0;
                busy_d   = 1'b1;
                eff_st   = WAIT_A;
                state_d  = WAIT_A;
            end
            case (eff_st)
                WAIT_A: begin
                    if (!sel) begin
                        a_hold_d = bus.ui_in;
                        state_d  = WAIT_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                WAIT_B: begin
                    if (sel) begin
                        uo_d     = diff[7:0];
                        borrow_d = diff[8];
                        if (cnt_q == CW'(NBYTES - 1)) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            bout_d  = diff[8];
                        end else begin
                            cnt_d   = cnt_q + CW'(1);
                            state_d = WAIT_A;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    assign bus.uo_out  = uo_q;
    assign bus.uio_out = {err_q, bout_q, done_q, busy_q, 4'b0000};
    assign bus.uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_ksa_frame_subtractor.sv
// Directed bench for the frame subtractor: a table of strobe events with
// hand-computed uo_out/status, plus reset, latency and glitch sequences.
module tb_tt_ksa_frame_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tt_ksa_frame_subtractor_if bus ();

    tt_ksa_frame_subtractor #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       st;
        logic       sel;
        logic [7:0] d;
        logic [7:0] exp_uo;
        logic [3:0] exp_stat; // {error, borrow_out, done, busy}
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic st, logic sel, logic [7:0] d,
                                logic [7:0] uo, logic [3:0] stat);
        vec_t v;
        v.st = st; v.sel = sel; v.d = d; v.exp_uo = uo; v.exp_stat = stat;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic st, input logic sel, input logic [7:0] d, input int hi);
        @(negedge clk);
        bus.ui_in  = d;
        bus.uio_in = {5'b0, sel, st, 1'b1};
        repeat (hi) @(negedge clk);
        bus.uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // no-borrow frame 0x12345678 - 0x02040608
        add(1,0,8'h78, 8'h00,4'b0001); add(0,1,8'h08, 8'h70,4'b0001);
        add(0,0,8'h56, 8'h70,4'b0001); add(0,1,8'h06, 8'h50,4'b0001);
        add(0,0,8'h34, 8'h50,4'b0001); add(0,1,8'h04, 8'h30,4'b0001);
        add(0,0,8'h12, 8'h30,4'b0001); add(0,1,8'h02, 8'h10,4'b0010);
        // borrow ripple 1 - 2
        add(1,0,8'h01, 8'h10,4'b0001); add(0,1,8'h02, 8'hFF,4'b0001);
        add(0,0,8'h00, 8'hFF,4'b0001); add(0,1,8'h00, 8'hFF,4'b0001);
        add(0,0,8'h00, 8'hFF,4'b0001); add(0,1,8'h00, 8'hFF,4'b0001);
        add(0,0,8'h00, 8'hFF,4'b0001); add(0,1,8'h00, 8'hFF,4'b0110);
        // protocol error in WAIT_A; cnt must not advance
        add(1,0,8'h05, 8'hFF,4'b0001); add(0,1,8'h03, 8'h02,4'b0001);
        add(0,1,8'h77, 8'h02,4'b1001);
        add(0,0,8'h10, 8'h02,4'b1001); add(0,1,8'h01, 8'h0F,4'b1001);
        add(0,0,8'h20, 8'h0F,4'b1001); add(0,1,8'h02, 8'h1E,4'b1001);
        add(0,0,8'h30, 8'h1E,4'b1001); add(0,1,8'h03, 8'h2D,4'b1010);
        // clean frame clears error: 0x100 - 0x1
        add(1,0,8'h00, 8'h2D,4'b0001); add(0,1,8'h01, 8'hFF,4'b0001);
        add(0,0,8'h01, 8'hFF,4'b0001); add(0,1,8'h00, 8'h00,4'b0001);
        add(0,0,8'h00, 8'h00,4'b0001); add(0,1,8'h00, 8'h00,4'b0001);
        add(0,0,8'h00, 8'h00,4'b0001); add(0,1,8'h00, 8'h00,4'b0010);
        // two pairs then abort with 4 pairs of 01 - 01
        add(1,0,8'h11, 8'h00,4'b0001); add(0,1,8'h22, 8'hEF,4'b0001);
        add(0,0,8'h33, 8'hEF,4'b0001); add(0,1,8'h11, 8'h21,4'b0001);
        add(1,0,8'h01, 8'h21,4'b0001); add(0,1,8'h01, 8'h00,4'b0001);
        add(0,0,8'h01, 8'h00,4'b0001); add(0,1,8'h01, 8'h00,4'b0001);
        add(0,0,8'h01, 8'h00,4'b0001); add(0,1,8'h01, 8'h00,4'b0001);
        add(0,0,8'h01, 8'h00,4'b0001); add(0,1,8'h01, 8'h00,4'b0010);
        // non-start event in DONE, then wrong sel in WAIT_B keeps a_hold
        add(0,0,8'h55, 8'h00,4'b1010);
        add(1,0,8'h44, 8'h00,4'b0001); add(0,0,8'h99, 8'h00,4'b1001);
        add(0,1,8'h04, 8'h40,4'b1001);

        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;

        // asynchronous reset mid-clock
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_uo", bus.uo_out, 8'h00);
        chk("rst_uio_out", bus.uio_out, 8'h00);
        chk("rst_uio_oe", bus.uio_oe, 8'hF0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_uo", bus.uo_out, 8'h00);
        chk("idle_uio_out", bus.uio_out, 8'h00);

        // latency: first sampled at edge 1, update at edge 3; long hold -> one event
        @(negedge clk);
        bus.ui_in  = 8'h5A;
        bus.uio_in = 8'b0000_0011;
        @(negedge clk) chk("lat_edge1_busy", {7'b0, bus.uio_out[4]}, 8'h00);
        @(negedge clk) chk("lat_edge2_busy", {7'b0, bus.uio_out[4]}, 8'h00);
        @(negedge clk) chk("lat_edge3_busy", {7'b0, bus.uio_out[4]}, 8'h01);
        repeat (7) @(negedge clk);
        bus.uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("long_hold_stat", {4'b0, bus.uio_out[7:4]}, 8'h01);

        for (int i = 0; i < tbl.size(); i++) begin
            strobe(tbl[i].st, tbl[i].sel, tbl[i].d, 3);
            if (bus.uo_out !== tbl[i].exp_uo)
                $display("  vector %0d uo_out", i);
            chk("vec_uo", bus.uo_out, tbl[i].exp_uo);
            if (bus.uio_out[7:4] !== tbl[i].exp_stat)
                $display("  vector %0d status", i);
            chk("vec_stat", {4'b0, bus.uio_out[7:4]}, {4'b0, tbl[i].exp_stat});
        end

        // reset mid-frame discards everything
        strobe(1'b1, 1'b0, 8'h80, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_uo", bus.uo_out, 8'h00);
        chk("midrst_uio_out", bus.uio_out, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // one-cycle glitch still yields one event: non-start in IDLE -> error
        strobe(1'b0, 1'b1, 8'hC3, 1);
        chk("glitch_uo", bus.uo_out, 8'h00);
        chk("glitch_stat", {4'b0, bus.uio_out[7:4]}, 8'h08);

        // fresh one-byte check after reset: no residual borrow from discarded frame
        strobe(1'b1, 1'b0, 8'h09, 3);
        strobe(1'b0, 1'b1, 8'h04, 3);
        chk("post_rst_uo", bus.uo_out, 8'h05);
        chk("post_rst_stat", {4'b0, bus.uio_out[7:4]}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
